// File: rtl/matrix_multiply.sv
// Sequential fp64 gains x states product using one shared multiplier and adder.
// Define MATRIX_MULTIPLY_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module matrix_multiply #(
    parameter int ROWS = 3,
    parameter int COLS = 11
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ROWS*COLS-1:0][63:0] input_gains_matrix,
    input  logic [COLS-1:0][63:0]      input_states_matrix,
    input  logic [31:0]                sample_time,
    output logic [ROWS-1:0][63:0]      output_matrix,
    output logic                       output_valid
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int GW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

`ifdef MATRIX_MULTIPLY_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef enum logic [2:0] {LOAD, MUL, ADD, PUBLISH, WAIT} state_e;

    function automatic logic [63:0] fp_pack(
        input logic               sgn,
        input logic signed [13:0] exp,
        input logic [52:0]        man,
        input logic               g,
        input logic               r,
        input logic               st
    );
        logic [53:0]        m;
        logic signed [13:0] e;
        m = {1'b0, man};
        e = exp;
        if (RNE && g && (r || st || man[0])) m = m + 54'd1;
        if (m[53]) begin
            m = m >> 1;
            e = e + 14'sd1;
        end
        if (e <= 14'sd0) return 64'd0;
        if (e >= 14'sd2047) return {sgn, 11'h7ff, 52'd0};
        return {sgn, e[10:0], m[51:0]};
    endfunction

    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic [105:0]       p;
        logic signed [13:0] e;
        logic               sgn;
        sgn = a[63] ^ b[63];
        p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        e = $signed({3'd0, a[62:52]}) + $signed({3'd0, b[62:52]}) - 14'sd1023;
        if (a[62:52] == 11'h7ff || b[62:52] == 11'h7ff) return {sgn, 11'h7ff, 52'd0};
        if (a[62:52] == 11'd0 || b[62:52] == 11'd0) return {sgn, 63'd0};
        if (p[105]) return fp_pack(sgn, e + 14'sd1, p[105:53], p[52], p[51], |p[50:0]);
        return fp_pack(sgn, e, p[104:52], p[51], p[50], |p[49:0]);
    endfunction

    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0]        x, y;
        logic [55:0]        mx, my, sh;
        logic [56:0]        s;
        logic [10:0]        d;
        logic signed [13:0] e;
        int                 lead;
        x = (a[62:52] == 11'd0) ? {a[63], 63'd0} : a;
        y = (b[62:52] == 11'd0) ? {b[63], 63'd0} : b;
        if (x[62:0] < y[62:0]) {x, y} = {y, x};
        mx = {x[62:52] != 11'd0, x[51:0], 3'd0};
        my = {y[62:52] != 11'd0, y[51:0], 3'd0};
        d = x[62:52] - y[62:52];
        if (d >= 11'd56) sh = {55'd0, |my};
        else sh = (my >> d) | {55'd0, |(my & ((56'd1 << d) - 56'd1))};
        s = (x[63] ^ y[63]) ? {1'b0, mx} - {1'b0, sh} : {1'b0, mx} + {1'b0, sh};
        e = $signed({3'd0, x[62:52]});
        lead = 0;
        for (int i = 0; i < 57; i++) if (s[i]) lead = i;
        // leading one lands on bit 55; the bits below it are guard/round/sticky
        if (s[56]) begin
            s = {1'b0, s[56:2], s[1] | s[0]};
            e = e + 14'sd1;
        end else begin
            s = s << (55 - lead);
            e = e + 14'(lead) - 14'sd55;
        end
        if (x[62:52] == 11'h7ff) return x;
        if (s == 57'd0) return 64'd0;
        return fp_pack(x[63], e, s[55:3], s[2], s[1], s[0]);
    endfunction

    state_e                     state_q, state_d;
    logic [ROWS*COLS-1:0][63:0] g_q;
    logic [COLS-1:0][63:0]      s_q;
    logic [ROWS-1:0][63:0]      row_q;
    logic [63:0]                prod_q, acc_q, acc_sum;
    logic [RW-1:0]              r_q;
    logic [KW-1:0]              k_q;
    logic [GW-1:0]              gidx;
    logic [31:0]                cnt_q, st_min;
    logic                       pub_q;
    logic                       do_ld, do_mul, do_add, do_pub;

    assign st_min  = (sample_time == 32'd0) ? 32'd1 : sample_time;
    assign gidx    = GW'(32'(r_q) * 32'(COLS) + 32'(k_q));
    assign acc_sum = fp_add(acc_q, prod_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    state_d = MUL;
            MUL:     state_d = ADD;
            ADD: begin
                if (k_q == KW'(COLS - 1) && r_q == RW'(ROWS - 1)) state_d = PUBLISH;
                else state_d = MUL;
            end
            PUBLISH: state_d = WAIT;
            WAIT:    if (cnt_q >= st_min - 32'd1) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        do_ld  = 1'b0;
        do_mul = 1'b0;
        do_add = 1'b0;
        do_pub = 1'b0;
        unique case (state_q)
            LOAD:    do_ld  = 1'b1;
            MUL:     do_mul = 1'b1;
            ADD:     do_add = 1'b1;
            PUBLISH: do_pub = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            g_q           <= '0;
            s_q           <= '0;
            row_q         <= '0;
            prod_q        <= '0;
            acc_q         <= '0;
            r_q           <= '0;
            k_q           <= '0;
            cnt_q         <= '0;
            pub_q         <= 1'b0;
            output_matrix <= '0;
            output_valid  <= 1'b0;
        end else begin
            pub_q <= do_pub;
            if (do_ld) cnt_q <= 32'd1;
            else if (cnt_q != 32'hffff_ffff) cnt_q <= cnt_q + 32'd1;
            // whole result lands in one edge; the row buffers are never exposed
            if (pub_q) begin
                output_matrix <= row_q;
                output_valid  <= 1'b1;
            end
            if (do_ld) begin
                g_q   <= input_gains_matrix;
                s_q   <= input_states_matrix;
                acc_q <= '0;
                r_q   <= '0;
                k_q   <= '0;
            end
            if (do_mul) prod_q <= fp_mul(g_q[gidx], s_q[k_q]);
            if (do_add) begin
                if (k_q == KW'(COLS - 1)) begin
                    row_q[r_q] <= acc_sum;
                    acc_q      <= '0;
                    k_q        <= '0;
                    r_q        <= r_q + RW'(1);
                end else begin
                    acc_q <= acc_sum;
                    k_q   <= k_q + KW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_multiply.sv
// Directed/randomized bench for matrix_multiply against a real-arithmetic model.
module tb_matrix_multiply;
    localparam int ROWS = 3;
    localparam int COLS = 11;
    localparam int N    = ROWS * COLS;
    localparam int LAT  = 2 * ROWS * COLS + 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N-1:0][63:0]    gains;
    logic [COLS-1:0][63:0] states;
    logic [31:0]           sample_time;
    logic [ROWS-1:0][63:0] out_m;
    logic                  out_v;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat;
    int          L;
    logic        vgood;
    real         gr[N];
    real         sr[COLS];
    logic [63:0] exp_new[ROWS];
    logic [63:0] exp_ld[ROWS];
    logic [63:0] exp_prev[ROWS];
    real         ramp_ref[ROWS] = '{506.0, 1232.0, 1958.0};

    matrix_multiply #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clock               (clock),
        .reset               (reset),
        .input_gains_matrix  (gains),
        .input_states_matrix (states),
        .sample_time         (sample_time),
        .output_matrix       (out_m),
        .output_valid        (out_v)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ex);
        checks++;
        assert (obs === ex)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ex);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic apply();
        real acc;
        for (int i = 0; i < N; i++) gains[i] = $realtobits(gr[i]);
        for (int k = 0; k < COLS; k++) states[k] = $realtobits(sr[k]);
        for (int r = 0; r < ROWS; r++) begin
            acc = 0.0;
            for (int k = 0; k < COLS; k++) acc = acc + gr[r*COLS+k] * sr[k];
            exp_new[r] = $realtobits(acc);
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) gr[i] = real'(i + 1);
        for (int k = 0; k < COLS; k++) sr[k] = real'(k + 1);
        apply();
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++) gr[i] = real'(int'($urandom_range(0, 256)) - 128) / 4.0;
        for (int k = 0; k < COLS; k++) sr[k] = real'(int'($urandom_range(0, 256)) - 128) / 4.0;
        apply();
    endtask

    task automatic set_alt();
        set_rand();
        for (int k = 0; k < COLS; k++) gr[k] = (k % 2 == 0) ? 2.5 : -2.5;
        for (int k = 0; k < COLS; k++) sr[k] = 4.0;
        apply();
    endtask

    task automatic set_inf();
        for (int i = 0; i < N; i++) gr[i] = 0.0;
        for (int k = 0; k < COLS; k++) sr[k] = 0.0;
        gr[0] = 1.0e308;
        gr[1] = 1.0e308;
        sr[0] = 10.0;
        sr[1] = 10.0;
        apply();
    endtask

    task automatic check_rows(input string tag, input logic [63:0] ex[ROWS]);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s_row%0d", tag, r), out_m[r], ex[r]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, out_v}, 64'd0);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s_out%0d", tag, r), out_m[r], 64'd0);
    endtask

    task automatic wait_first(input string tag);
        lat = -1;
        while (cyc < LAT + 5) begin
            step();
            if (cyc == 10) set_rand();
            if (out_v && lat < 0) lat = cyc;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    endtask

    initial begin
        reset       = 1'b0;
        sample_time = 32'd1000;
        set_ramp();
        repeat (2) begin
            @(negedge clock);
            check_zero("reset");
        end

        // first LOAD on the next rising edge
        reset = 1'b1;
        cyc   = -1;
        exp_ld = exp_new;
        wait_first("first");
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("ramp_row%0d", r), out_m[r], $realtobits(ramp_ref[r]));
        exp_prev = exp_new;

        vgood = 1'b1;
        while (cyc < 1000 + LAT - 1) begin
            step();
            if (!out_v) vgood = 1'b0;
        end
        chk("valid_hold", {63'd0, vgood}, 64'd1);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("ramp_kept_row%0d", r), out_m[r], $realtobits(ramp_ref[r]));
        step();
        check_rows("second", exp_prev);

        sample_time = 32'd5;
        set_alt();
        L = cyc + 2;
        for (int j = 0; j < 4; j++) begin
            exp_ld = exp_new;
            run_to(L + 10);
            if (j == 0) set_inf();
            else set_rand();
            run_to(L + LAT - 1);
            check_rows($sformatf("b2b%0d_before", j), exp_prev);
            chk($sformatf("b2b%0d_valid", j), {63'd0, out_v}, 64'd1);
            step();
            check_rows($sformatf("b2b%0d_after", j), exp_ld);
            if (j == 0) chk("alt_row0", out_m[0], $realtobits(10.0));
            if (j == 1) chk("inf_row0", out_m[0], 64'h7ff0_0000_0000_0000);
            exp_prev = exp_ld;
            L = L + LAT + 1;
        end

        // abort in the middle of row 1
        run_to(L + 30);
        reset = 1'b0;
        #1;
        check_zero("abort");
        sample_time = 32'd1000;
        set_rand();
        @(negedge clock);
        @(negedge clock);
        check_zero("abort_hold");
        reset  = 1'b1;
        cyc    = -1;
        exp_ld = exp_new;
        wait_first("restart");
        check_rows("restart", exp_ld);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_multiply.md
Name: matrix_multiply

Overview:
- Periodic fp64 matrix-vector multiplier for the controller datapath: output = gains (ROWS x COLS) times states (COLS x 1).
- Captures both operands at the start of each sample period and computes sequentially with one shared multiplier and one shared adder.
- Publishes the ROWS-element result atomically, then raises output_valid.
- Sits between the state estimator and the actuator command stage.

Parameters:
- ROWS, 3, gain-matrix rows = output length
- COLS, 11, gain-matrix columns = state-vector length

Ports:
- clock  in  1  system clock; all state on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- input_gains_matrix  in  [ROWS*COLS-1:0][63:0]  IEEE-754 doubles, row-major; element i is row i/COLS, column i%COLS
- input_states_matrix  in  [COLS-1:0][63:0]  IEEE-754 doubles; element k is state k
- sample_time  in  32  period between computation starts, in clock cycles
- output_matrix  out  [ROWS-1:0][63:0]  result doubles; element r = sum over k of g[r*COLS+k]*s[k]
- output_valid  out  1  high once the first result is published

Behaviour:
- Reset, asynchronous, reset==0: output_matrix all zero, output_valid=0, FSM in LOAD, period counter=0, accumulator=+0.
- Reset asserted mid-computation aborts it immediately and discards partial sums.
- FSM states: LOAD, MUL, ADD, PUBLISH, WAIT.
- LOAD (1 cycle):
  - registers every gain and state word internally; later input changes do not affect this computation;
  - clears the accumulator; row r=0, term k=0.
- MUL (1 cycle): product register <= g[r*COLS+k] * s[k].
- ADD (1 cycle):
  - accumulator <= accumulator + product;
  - if k<COLS-1: k++ and go to MUL;
  - else: store the accumulator into internal row buffer r, clear it, k=0;
  - then r++ and go to MUL if r<ROWS-1, otherwise go to PUBLISH.
- PUBLISH (1 cycle): copy all row buffers into output_matrix in a single edge and set output_valid=1.
  - Partial results are never visible.
- output_valid stays high until reset. It does not drop between computations.
- Latency is 2*ROWS*COLS+2 cycles from the LOAD edge to the PUBLISH edge: 68 cycles with the defaults.
- Period counter:
  - counts cycles since the last LOAD;
  - WAIT returns to LOAD when counter >= sample_time-1 (sample_time 0 is treated as 1);
  - if sample_time is shorter than the latency, the next LOAD follows PUBLISH immediately (back-to-back operation);
  - sample_time is sampled every cycle, so a change applies to the current wait.
- The first LOAD occurs on the first rising edge after reset deasserts.
- fp64 rules, multiplier and adder:
  - zero or subnormal operands are treated as +-0;
  - round toward zero;
  - exponent overflow gives +-infinity;
  - underflow flushes to +0;
  - an exact-cancellation sum is +0;
  - NaN/Inf inputs produce an unspecified value but must never stall the FSM;
  - integer-valued products and sums below 2^53 must be exact.

Optional Feature:
- Macro MATRIX_MULTIPLY_ROUND_NEAREST_EN.
- When defined: the multiplier and adder round to nearest, ties to even, using guard/round/sticky bits. Everything else, including latency, is unchanged.
- When undefined: round toward zero, as specified above.

Test Plan:
- Reset low for 2 cycles, then released:
  - output_matrix=0 and output_valid=0 during reset;
  - the first LOAD on the next edge;
  - output_valid rises exactly 68 cycles later.
- Gains i+1.0 (i=0..32), states k+1.0 (k=0..10), sample_time=1000 -> output = {506.0, 1232.0, 1958.0} exactly, output_valid=1.
- Same stimulus, then inputs changed 10 cycles after LOAD:
  - the result is still {506, 1232, 1958};
  - the new inputs appear in the result published after the next LOAD, 1000 cycles after the first;
  - output_valid stays high throughout.
- sample_time=5 (shorter than the latency) -> LOADs occur every 69 cycles back-to-back, and each result matches its captured inputs.
- Row 0 gains alternating +2.5/-2.5 with all states 4.0 (11 terms) -> row 0 = 10.0. Gains {1e308, 1e308, 0...} with states {10, 10, 0...} -> +infinity.
- Reset pulsed low mid-computation, in row 1 -> outputs zero and output_valid=0 immediately; a fresh computation publishes 68 cycles after the next LOAD.
